// File: rtl/processing_element_ws_pkg.sv
// Shared constants for the weight-stationary processing element.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package processing_element_ws_pkg;

   localparam logic MODE_LOAD    = 1'b0;
   localparam logic MODE_COMPUTE = 1'b1;

   localparam int DEFAULT_WORDWIDTH = 8;

   // Partial sums carry four operand widths so long dot products rarely wrap.
   function automatic int psum_width(input int wordwidth);
      return 4 * wordwidth;
   endfunction

endpackage

// File: rtl/processing_element_ws_if.sv
// Neighbour-facing signal bundle of one PE (everything except clk and reset).
// Latency: n/a (wiring only).
// Backpressure: none; signals are plain valid-qualified data.
interface processing_element_ws_if
   import processing_element_ws_pkg::*;
#(
   parameter int WORDWIDTH = DEFAULT_WORDWIDTH
) ();

   localparam int PSUM_WIDTH = psum_width(WORDWIDTH);

   logic                  mode;
   logic                  enable_in;
   logic [WORDWIDTH-1:0]  w_in;
   logic [WORDWIDTH-1:0]  a_in;
   logic [PSUM_WIDTH-1:0] ps_in;
   logic                  enable_out;
   logic [WORDWIDTH-1:0]  w_out;
   logic [WORDWIDTH-1:0]  a_out;
   logic [PSUM_WIDTH-1:0] ps_out;

   // Upstream side: drives the PE inputs and observes its outputs.
   modport master (
      output mode, enable_in, w_in, a_in, ps_in,
      input  enable_out, w_out, a_out, ps_out
   );

   // PE side.
   modport slave (
      input  mode, enable_in, w_in, a_in, ps_in,
      output enable_out, w_out, a_out, ps_out
   );

endinterface

// File: rtl/processing_element_ws_pe_mac.sv
// Signed multiply-accumulate: ps + w*a, product sign-extended to the psum width.
// Latency: combinational.
// Backpressure: none.
module pe_mac
   import processing_element_ws_pkg::*;
#(
   parameter int WORDWIDTH = DEFAULT_WORDWIDTH
) (
   input  logic [WORDWIDTH-1:0]               i_w,
   input  logic [WORDWIDTH-1:0]               i_a,
   input  logic [psum_width(WORDWIDTH)-1:0]   i_ps,
   output logic [psum_width(WORDWIDTH)-1:0]   o_sum
);

   localparam int PSUM_WIDTH = psum_width(WORDWIDTH);
   localparam int PROD_WIDTH = 2 * WORDWIDTH;

   logic [PROD_WIDTH-1:0] w_w_ext;
   logic [PROD_WIDTH-1:0] w_a_ext;
   logic [PROD_WIDTH-1:0] w_prod;
   logic [PSUM_WIDTH-1:0] w_prod_ext;

   // Sign-extend operands first so an unsigned multiply of the low bits
   // yields the exact two's-complement product.
   assign w_w_ext    = {{WORDWIDTH{i_w[WORDWIDTH-1]}}, i_w};
   assign w_a_ext    = {{WORDWIDTH{i_a[WORDWIDTH-1]}}, i_a};
   assign w_prod     = w_w_ext * w_a_ext;
   assign w_prod_ext = {{(PSUM_WIDTH-PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

   // Accumulate wraps modulo 2^PSUM_WIDTH.
   assign o_sum = i_ps + w_prod_ext;

endmodule

// File: rtl/processing_element_ws.sv
// Weight-stationary systolic PE: shifts weights in LOAD, does MAC in COMPUTE.
// Latency: every output is registered, 1 cycle from the sampled inputs.
// Backpressure: none; enable_in qualifies inputs, upstream holds mode per phase.
module processing_element_ws
   import processing_element_ws_pkg::*;
#(
   parameter int WORDWIDTH = DEFAULT_WORDWIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,   // active-high despite the name
   processing_element_ws_if.slave  pe
);

   localparam int PSUM_WIDTH = psum_width(WORDWIDTH);

   logic [WORDWIDTH-1:0]  r_w;
   logic [WORDWIDTH-1:0]  r_a;
   logic [PSUM_WIDTH-1:0] r_ps;
   logic                  r_en;
   logic [PSUM_WIDTH-1:0] w_mac_sum;

   pe_mac #(
      .WORDWIDTH (WORDWIDTH)
   ) u_mac (
      .i_w   (r_w),
      .i_a   (pe.a_in),
      .i_ps  (pe.ps_in),
      .o_sum (w_mac_sum)
   );

   // State update: reset wins; enable gates every data register, en always tracks.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_w  <= '0;
         r_a  <= '0;
         r_ps <= '0;
         r_en <= 1'b0;
      end else begin
         r_en <= pe.enable_in;
         if (pe.enable_in) begin
            if (pe.mode == MODE_LOAD) begin
               r_w <= pe.w_in;
            end else begin
               r_a  <= pe.a_in;
               r_ps <= w_mac_sum;
            end
         end
      end
   end

   assign pe.w_out      = r_w;
   assign pe.a_out      = r_a;
   assign pe.ps_out     = r_ps;
   assign pe.enable_out = r_en;

endmodule

// File: tb/tb_processing_element_ws.sv
// Directed self-checking bench for processing_element_ws.
// Latency: each stimulus vector is checked 1 cycle after it is applied.
// Backpressure: n/a.
module tb_processing_element_ws;
   import processing_element_ws_pkg::*;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   processing_element_ws_if #(.WORDWIDTH(8)) pe_if ();

   processing_element_ws #(
      .WORDWIDTH (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pe      (pe_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Apply one input vector, clock it in, then settle away from the edge.
   task automatic drive(input logic rst, input logic md, input logic en,
                        input logic [7:0] w, input logic [7:0] a,
                        input logic [31:0] ps);
      reset_n         = rst;
      pe_if.mode      = md;
      pe_if.enable_in = en;
      pe_if.w_in      = w;
      pe_if.a_in      = a;
      pe_if.ps_in     = ps;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] w, input logic [7:0] a,
                            input logic [31:0] ps, input logic en);
      check({tag, ".w"},  {24'h0, pe_if.w_out}, {24'h0, w});
      check({tag, ".a"},  {24'h0, pe_if.a_out}, {24'h0, a});
      check({tag, ".ps"}, pe_if.ps_out, ps);
      check({tag, ".en"}, {31'h0, pe_if.enable_out}, {31'h0, en});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n         = 1'b1;
      pe_if.mode      = MODE_LOAD;
      pe_if.enable_in = 1'b0;
      pe_if.w_in      = '0;
      pe_if.a_in      = '0;
      pe_if.ps_in     = '0;
      #2;

      // Reset with busy-looking inputs must still clear everything.
      drive(1'b1, MODE_COMPUTE, 1'b1, 8'd5, 8'd7, 32'd100);
      check_all("reset", 8'd0, 8'd0, 32'd0, 1'b0);

      // Load weight 3; a/ps hold at 0.
      drive(1'b0, MODE_LOAD, 1'b1, 8'd3, 8'd9, 32'd77);
      check_all("load3", 8'd3, 8'd0, 32'd0, 1'b1);

      // First compute uses the just-loaded weight; w_in=50 must be ignored.
      drive(1'b0, MODE_COMPUTE, 1'b1, 8'd50, 8'd2, 32'd5);
      check_all("mac11", 8'd3, 8'd2, 32'd11, 1'b1);

      // Same inputs held for 5 cycles: result stays 11, weight stays 3.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, MODE_COMPUTE, 1'b1, 8'd50, 8'd2, 32'd5);
         check("hold.ps", pe_if.ps_out, 32'd11);
         check("hold.w", {24'h0, pe_if.w_out}, 32'd3);
      end

      // Compute with enable low: data registers hold, enable_out drops.
      drive(1'b0, MODE_COMPUTE, 1'b0, 8'd50, 8'd9, 32'd100);
      check_all("gate_c", 8'd3, 8'd2, 32'd11, 1'b0);

      // Load with enable low: weight must not change.
      drive(1'b0, MODE_LOAD, 1'b0, 8'd9, 8'd0, 32'd0);
      check_all("gate_l", 8'd3, 8'd2, 32'd11, 1'b0);

      // Reset mid-run clears weight and outputs.
      drive(1'b1, MODE_COMPUTE, 1'b1, 8'd1, 8'd1, 32'd1);
      check_all("rst_mid", 8'd0, 8'd0, 32'd0, 1'b0);

      // Weight is now 0, so the MAC passes ps_in straight through.
      drive(1'b0, MODE_COMPUTE, 1'b1, 8'd3, 8'd2, 32'd5);
      check_all("post_rst", 8'd0, 8'd2, 32'd5, 1'b1);

      // Negative weight: 10 + (-4)*7 = -18.
      drive(1'b0, MODE_LOAD, 1'b1, 8'hFC, 8'd0, 32'd0);
      check("ld_m4.w", {24'h0, pe_if.w_out}, 32'h0000_00FC);
      drive(1'b0, MODE_COMPUTE, 1'b1, 8'd0, 8'd7, 32'd10);
      check_all("neg", 8'hFC, 8'd7, 32'hFFFF_FFEE, 1'b1);

      // Most-negative operands: 0x7FFFFFFF + 16384 wraps to 0x80003FFF.
      drive(1'b0, MODE_LOAD, 1'b1, 8'h80, 8'd0, 32'd0);
      check("ld_m128.w", {24'h0, pe_if.w_out}, 32'h0000_0080);
      drive(1'b0, MODE_COMPUTE, 1'b1, 8'd0, 8'h80, 32'h7FFF_FFFF);
      check_all("wrap", 8'h80, 8'h80, 32'h8000_3FFF, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/processing_element_ws.md
# processing_element_ws

Weight-stationary processing element (PE) for an integer systolic-array matrix multiplier. Each PE holds one weight loaded through a vertical shift chain. In compute mode it multiplies the activation arriving from the left by the stored weight and adds the partial sum arriving from above. It forwards the activation right, the partial sum down, and the enable along the array, each with a one-cycle register stage.

## Interface
- WORDWIDTH, default 8: bit width of weights and activations. The partial sum is 4*WORDWIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, synchronous, active-high: asserted when 1 despite the name.
- mode  input  1  0 = LOAD (weight shift), 1 = COMPUTE (MAC).
- enable_in  input  1  qualifies all inputs this cycle.
- w_in  input  WORDWIDTH  weight from the PE above, or from the array edge.
- a_in  input  WORDWIDTH  activation from the PE to the left.
- ps_in  input  4*WORDWIDTH  partial sum from the PE above.
- enable_out  output  1  registered enable_in, to the neighbour.
- w_out  output  WORDWIDTH  current stored weight, to the PE below.
- a_out  output  WORDWIDTH  registered activation, to the PE to the right.
- ps_out  output  4*WORDWIDTH  registered partial sum, to the PE below.

## Operation
- State registers: w_reg, a_reg, ps_reg, en_reg. Outputs drive these directly: w_out=w_reg, a_out=a_reg, ps_out=ps_reg, enable_out=en_reg.
- Reset (reset_n=1 at a rising edge): all four registers are cleared to 0. Reset has priority over every other input.
- en_reg is loaded with enable_in on every non-reset edge, in both modes.
- LOAD, enable_in=1:
  - w_reg is loaded with w_in.
  - a_reg and ps_reg hold.
  - A column of N PEs therefore loads N weights in N cycles, fed bottom weight first.
- COMPUTE, enable_in=1:
  - a_reg is loaded with a_in.
  - ps_reg is loaded with ps_in + w_reg*a_in.
  - w_reg holds.
- enable_in=0, either mode: w_reg, a_reg and ps_reg hold. Only en_reg updates, to 0.
- Arithmetic:
  - Operands are signed two's complement.
  - The WORDWIDTH×WORDWIDTH product is 2*WORDWIDTH bits, sign-extended to 4*WORDWIDTH.
  - The add wraps modulo 2^(4*WORDWIDTH). There is no saturation and no overflow flag.
- A mode change takes effect at the next edge. The weight loaded in the last LOAD cycle is used by the first COMPUTE cycle.

## Timing
- Every output has exactly 1-cycle latency from the inputs sampled at the edge. There are no combinational paths from input to output.
- Reset asserted mid-computation: the next edge clears the weight and all outputs to 0. Operation resumes on the first edge after deassertion, and the weight must be reloaded.
- No handshake or back-pressure exists. The upstream side must hold mode stable across an array-wide phase.

## Structure
- Shared package holds:
  - MODE_LOAD=1'b0 and MODE_COMPUTE=1'b1.
  - The default WORDWIDTH.
  - The PSUM_WIDTH = 4*WORDWIDTH rule.
- One combinational sub-module, pe_mac, computes ps_in + w*a with the sign extension above. The PE top contains only the registers and the mode/enable muxing.

## Test plan
- Reset: drive reset_n=1 for one edge with arbitrary inputs -> w_out, a_out and ps_out all 0, and enable_out=0.
- Load then compute:
  - Cycle 1: mode=0, enable_in=1, w_in=3 -> w_out=3.
  - Cycle 2: mode=1, a_in=2, ps_in=5 -> ps_out=11 and a_out=2.
  - Held for 5 cycles -> ps_out stays 11 and w_out stays 3.
- Signed and wrap:
  - Weight -4 (8'hFC), a_in=7, ps_in=10 -> ps_out = -18 (32'hFFFFFFEE).
  - Weight -128, a_in=-128, ps_in=32'h7FFFFFFF -> ps_out = 32'h80003FFF (wraps).
- Enable gating: in COMPUTE with enable_in=0 and new a_in and ps_in -> a_out and ps_out keep their prior values, enable_out=0. In LOAD with enable_in=0 and w_in=9 -> w_out unchanged.
- Weight held in compute: mode=1, w_in changes to 50 -> w_out and the MAC keep using the loaded weight.
- Reset mid-run: after the load/compute sequence, assert reset for one edge -> all outputs 0. Then a compute edge with a_in=2, ps_in=5 gives ps_out=5, because the weight is 0.
